seg_scan_mux: RTL

- Time-multiplexed driver for one 4-digit, common-anode 7-segment bank.
- Sits directly downstream of the switch/button logic.
- Takes a 16-bit hex value plus per-digit enable and decimal-point masks, encodes each nibble internally, and cycles the anodes so all four digits appear lit simultaneously.
- Double-buffers the value so updates take effect only on a frame boundary, with no tearing.

---
 rtl/seg_scan_mux.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a 4-digit common-anode 7-segment bank.
// Encodes the nibbles of a double-buffered 16-bit value and scans the anodes so all
// four digits appear lit at once. A new value only becomes visible at a frame boundary.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable (0 = display dark, scan held at digit 0 / tick 0)
//   load        single-cycle strobe capturing value/dig_en/dp
//   value       hex value, [3:0] = rightmost digit (an[0])
//   dig_en      per-digit enable, 1 = digit shown
//   dp          per-digit decimal point, 1 = dot on
//   seg         active-low segments {dp,g,f,e,d,c,b,a}
//   an          active-low anodes, an[0] = rightmost digit
//   frame_tick  one-cycle pulse following each frame boundary
//
// Optional feature: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading-zero
// digits (digit k>0 is dark when active nibbles k..3 are all zero).
module seg_scan_mux #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;
  logic [15:0]   act_val_q, act_val_d;
  logic [3:0]    act_en_q, act_en_d;
  logic [3:0]    act_dp_q, act_dp_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_en_q, pend_en_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;

  logic          tick_end;
  logic          commit;
  logic          in_blank;
  logic          show;
  logic [3:0]    nib;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] enc7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state: scan counters, output decode, double-buffer handling
  always_comb begin
    tick_d       = tick_q;
    idx_d        = idx_q;
    seg_d        = seg_q;
    an_d         = an_q;
    ft_d         = 1'b0;
    act_val_d    = act_val_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    tick_end = (tick_q == TICK_LAST);
    commit   = en && (idx_q == 2'd3) && tick_end;
    in_blank = (32'(tick_q) < BLANK_TICKS);
    nib      = 4'(act_val_q >> {idx_q, 2'b00});
    show     = !in_blank && act_en_q[idx_q];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Shifting out the lower nibbles leaves nibbles idx..3; all zero means leading zero
    if ((idx_q != 2'd0) && ((act_val_q >> {idx_q, 2'b00}) == 16'h0000)) begin
      show = 1'b0;
    end
`endif

    if (!en) begin
      tick_d = '0;
      idx_d  = 2'd0;
      seg_d  = 8'hFF;
      an_d   = 4'hF;
      // Nothing is on screen, so a load can go straight to the active copy
      if (load) begin
        act_val_d    = value;
        act_en_d     = dig_en;
        act_dp_d     = dp;
        pend_valid_d = 1'b0;
      end
    end else begin
      seg_d = show ? {~act_dp_q[idx_q], enc7(nib)} : 8'hFF;
      an_d  = show ? ~(4'b0001 << idx_q) : 4'hF;
      ft_d  = commit;

      if (tick_end) begin
        tick_d = '0;
        idx_d  = 2'(idx_q + 2'd1);
      end else begin
        tick_d = TW'(tick_q + 1'b1);
      end

      if (commit) begin
        // A load on the boundary edge is newest and bypasses the pending copy
        if (load) begin
          act_val_d    = value;
          act_en_d     = dig_en;
          act_dp_d     = dp;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          act_val_d    = pend_val_q;
          act_en_d     = pend_en_q;
          act_dp_d     = pend_dp_q;
          pend_valid_d = 1'b0;
        end
      end else if (load) begin
        pend_val_d   = value;
        pend_en_d    = dig_en;
        pend_dp_d    = dp;
        pend_valid_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q       <= '0;
      idx_q        <= 2'd0;
      seg_q        <= 8'hFF;
      an_q         <= 4'hF;
      ft_q         <= 1'b0;
      act_val_q    <= 16'h0000;
      act_en_q     <= 4'h0;
      act_dp_q     <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_en_q    <= 4'h0;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      ft_q         <= ft_d;
      act_val_q    <= act_val_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule
